// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
//   Bundles the display-side signals of the seven-segment scan controller.
//   master : the side that supplies display content and reads back the pins
//   slave  : the scan controller itself
//
//   en         scan enable; 0 forces the display dark
//   data       eight hex nibbles, digit i = data[4i+3:4i]
//   dig_mask   per-digit enable, 1 = lit
//   dp         per-digit decimal point, 1 = lit
//   AN         anode selects, active-low
//   SEG        segments {g,f,e,d,c,b,a}, active-low
//   DP         decimal point, active-low
//   frame_done one-cycle pulse at the end of every 8-digit frame
interface seg_scan_ctrl_if;
  logic        en;
  logic [31:0] data;
  logic [7:0]  dig_mask;
  logic [7:0]  dp;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        frame_done;

  modport master (
    output en, data, dig_mask, dp,
    input  AN, SEG, DP, frame_done
  );

  modport slave (
    input  en, data, dig_mask, dp,
    output AN, SEG, DP, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit seven-segment display.
//   One digit slot is DIV clocks long: DIV-BLANK clocks showing the digit,
//   then BLANK clocks dark to suppress ghosting. Display inputs are
//   snapshotted when scanning starts and again at every frame wrap, so a
//   frame never mixes old and new data. All outputs are registered.
//
//   Parameters
//     DIV    clocks per digit slot (2 .. 2^20-1)
//     BLANK  dark clocks at the end of each slot (0 .. DIV-1)
//
//   Ports
//     CLK100MHZ  system clock, rising edge
//     rst        synchronous reset, active-high, priority over en
//     bus        seg_scan_ctrl_if slave modport (en, data, dig_mask, dp in;
//                AN, SEG, DP, frame_done out)
module seg_scan_ctrl #(
  parameter int unsigned DIV   = 100_000,
  parameter int unsigned BLANK = 1_000
) (
  input  logic           CLK100MHZ,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  // Last count of the slot, and last count of the lit part of the slot.
  // With BLANK=0 both are the same and the boundary fires straight from SHOW.
  localparam logic [19:0] SlotLast = 20'(DIV - 1);
  localparam logic [19:0] ShowLast = 20'(DIV - BLANK - 1);
  localparam bit          HasBlank = (BLANK != 0);

  typedef enum logic [1:0] {
    StOff,
    StShow,
    StBlank
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;

  // Frame snapshot of the display inputs
  logic [31:0] data_s_q, data_s_d;
  logic [7:0]  mask_s_q, mask_s_d;
  logic [7:0]  dp_s_q, dp_s_d;

  // Registered outputs
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic        boundary;
  logic        load_snap;
  logic [3:0]  nibble;
  logic [7:0]  an_onehot;

  // Hex to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    data_s_d     = data_s_q;
    mask_s_d     = mask_s_q;
    dp_s_d       = dp_s_q;
    frame_done_d = 1'b0;
    boundary     = 1'b0;
    load_snap    = 1'b0;

    unique case (state_q)
      StOff: begin
        if (bus.en) begin
          state_d   = StShow;
          cnt_d     = '0;
          idx_d     = '0;
          load_snap = 1'b1;
        end
      end
      StShow: begin
        if (!bus.en) begin
          state_d = StOff;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == ShowLast) begin
          if (HasBlank) begin
            state_d = StBlank;
            cnt_d   = cnt_q + 20'd1;
          end else begin
            boundary = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      StBlank: begin
        if (!bus.en) begin
          state_d = StOff;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == SlotLast) begin
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Slot boundary, shared by the SHOW (BLANK=0) and BLANK paths.
    // idx wraps 7->0 naturally in 3 bits.
    if (boundary) begin
      state_d = StShow;
      cnt_d   = '0;
      idx_d   = idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        frame_done_d = 1'b1;
        load_snap    = 1'b1;
      end
    end

    if (load_snap) begin
      data_s_d = bus.data;
      mask_s_d = bus.dig_mask;
      dp_s_d   = bus.dp;
    end
  end

  // Outputs are decoded from the next state, index and snapshot so the new
  // digit (and a freshly loaded snapshot) appear on the same edge.
  always_comb begin
    an_d      = 8'hFF;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    nibble    = data_s_d[{idx_d, 2'b00} +: 4];
    an_onehot = 8'd1 << idx_d;
    if (state_d == StShow) begin
      seg_d = hex_decode(nibble);
      if (mask_s_d[idx_d]) begin
        an_d = ~an_onehot;
        dp_d = ~dp_s_d[idx_d];
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q      <= StOff;
      cnt_q        <= '0;
      idx_q        <= '0;
      data_s_q     <= '0;
      mask_s_q     <= '0;
      dp_s_q       <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      data_s_q     <= data_s_d;
      mask_s_q     <= mask_s_d;
      dp_s_q       <= dp_s_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;
  assign bus.DP         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule
